// File: rtl/leaf_arb_pkg.sv
// Shared types and constants for the leaf output arbiter: FSM state encoding,
// statistics counter width and default parameter values.
package leaf_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int STAT_BITS = 32;

  localparam int DEF_NUM_PORTS    = 2;
  localparam int DEF_PORT_BITS    = 1;
  localparam int DEF_PAYLOAD_BITS = 32;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_BURST_BITS   = 8;

endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requester found when
// scanning upward from last+1, wrapping modulo NUM_PORTS.
module rr_pick
  import leaf_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int PORT_BITS = DEF_PORT_BITS
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_BITS-1:0] last,
  output logic                 any,
  output logic [PORT_BITS-1:0] sel
);

  int                   idx;
  logic [NUM_PORTS-1:0] rot;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    any = |req;
    sel = '0;
    idx = 0;
    rot = '0;
    // Scan from the farthest candidate back to the nearest so the nearest requester wins.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_PORTS;
      rot = req >> idx;
      if (rot[0]) sel = PORT_BITS'(idx);
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Burst-based round-robin arbiter merging NUM_PORTS kernel output streams into one
// tagged leaf_interface output. Optional per-port word counters under ARB_STATS_EN.
module leaf_out_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int PORT_BITS    = DEF_PORT_BITS,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int BURST_BITS   = DEF_BURST_BITS
) (
  input  logic                              clk_user,
  input  logic                              reset,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] in_data,
  input  logic [NUM_PORTS-1:0]              in_vld,
  output logic [NUM_PORTS-1:0]              in_ack,
  output logic [PAYLOAD_BITS-1:0]           out_data,
  output logic [PORT_BITS-1:0]              out_port,
  output logic                              out_vld,
  input  logic                              out_ack
`ifdef ARB_STATS_EN
  ,
  input  logic                              stat_clear,
  output logic [NUM_PORTS*STAT_BITS-1:0]    stat_words
`endif
);

  arb_state_e            state;
  logic [PORT_BITS-1:0]  gnt;
  logic [PORT_BITS-1:0]  last_grant;
  logic [BURST_BITS-1:0] burst_cnt;

  logic                    pick_any;
  logic [PORT_BITS-1:0]    pick_sel;
  logic [NUM_PORTS-1:0]    gnt_mask;
  logic                    gnt_vld;
  logic [PAYLOAD_BITS-1:0] gnt_data;
  logic                    out_ready;
  logic                    xfer;
  logic                    last_beat;

  rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .PORT_BITS(PORT_BITS)
  ) u_pick (
    .req (in_vld),
    .last(last_grant),
    .any (pick_any),
    .sel (pick_sel)
  );

  always_comb begin
    gnt_mask  = NUM_PORTS'(1) << gnt;
    gnt_vld   = |(in_vld & gnt_mask);
    gnt_data  = PAYLOAD_BITS'(in_data >> (int'(gnt) * PAYLOAD_BITS));
    out_ready = !out_vld || out_ack;
    xfer      = (state == GRANT) && gnt_vld && out_ready && !reset;
    last_beat = (burst_cnt == BURST_BITS'(MAX_BURST - 1));
    // Only the granted port may be acked, and never while reset is high.
    in_ack    = ((state == GRANT) && out_ready && !reset) ? (in_vld & gnt_mask) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      last_grant <= PORT_BITS'(NUM_PORTS - 1);
      burst_cnt  <= '0;
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_port   <= '0;
    end else begin
      // A load and a drain in the same cycle keep out_vld high for 1 word/cycle.
      if (xfer) begin
        out_data <= gnt_data;
        out_port <= gnt;
        out_vld  <= 1'b1;
      end else if (out_ack) begin
        out_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt       <= pick_sel;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (last_beat) begin
              state      <= IDLE;
              last_grant <= gnt;
            end
          end else if (!gnt_vld) begin
            state      <= IDLE;
            last_grant <= gnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stat
    logic [STAT_BITS-1:0] cnt;

    // Clear wins over a same-cycle increment; the count saturates instead of wrapping.
    always_ff @(posedge clk_user) begin
      if (reset || stat_clear) begin
        cnt <= '0;
      end else if (in_ack[i] && in_vld[i] && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stat_words[i*STAT_BITS +: STAT_BITS] = cnt;
  end
`endif

endmodule
